gdsp_frame_ctrl: RTL

Frame sequencer for the TX + AWGN chain. Generates the symbol-rate enable and builds each frame as preamble, then payload, then guard: fixed preamble symbols, then PRBS payload from bit_gen, then zero symbols that flush the RRC filter tails. Between frames it updates the channel noise magnitude, either by an automatic sweep or from a manual value. Sits between the board controls and bit_gen, qam16_mapper and channel_top, and replaces the free-running symbol counter in the top level.

---
 rtl/gdsp_frame_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gdsp_frame_ctrl.sv
// gdsp_frame_ctrl: symbol-rate frame sequencer (preamble, PRBS payload, zero guard)
// with per-frame channel noise magnitude update (auto sweep or manual).
module gdsp_frame_ctrl #(
    parameter int SPS          = 4,
    parameter int PREAMBLE_LEN = 16,
    parameter int PAYLOAD_LEN  = 256,
    parameter int GUARD_LEN    = 8,
    parameter int NOISE_MIN    = 0,
    parameter int NOISE_MAX    = 128,
    parameter int NOISE_STEP   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        auto_sweep_i,
    input  logic [7:0]  noise_manual_i,
    output logic        sym_tick_o,
    output logic        payload_en_o,
    output logic        pre_valid_o,
    output logic [3:0]  pre_bits_o,
    output logic [1:0]  src_sel_o,
    output logic [7:0]  noise_mag_o,
    output logic        frame_start_o,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o,
    output logic        busy_o
);
    localparam int MAXLEN = (PAYLOAD_LEN > PREAMBLE_LEN) ?
                            ((PAYLOAD_LEN > GUARD_LEN) ? PAYLOAD_LEN : GUARD_LEN) :
                            ((PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN);
    localparam int SW = $clog2(MAXLEN);
    localparam int PW = $clog2(SPS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PRE  = 2'd1;
    localparam logic [1:0] PAY  = 2'd2;
    localparam logic [1:0] GRD  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] sps_q, sps_d;
    logic [SW-1:0] sym_q, sym_d, cur_last;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]    noise_q, noise_d, sweep_mag;
    logic [8:0]    sweep;
    logic          stop_req_q, stop_req_d;
    logic          fs_q, fs_d, fd_q, fd_d;
    logic          busy, sym_tick, sym_end, last;

    assign busy     = state_q != IDLE;
    assign sym_tick = busy && sps_q == '0;
    assign sym_end  = busy && sps_q == PW'(SPS - 1);
    assign cur_last = state_q == PRE ? SW'(PREAMBLE_LEN - 1) :
                      state_q == PAY ? SW'(PAYLOAD_LEN - 1) : SW'(GUARD_LEN - 1);
    // a state ends after the final cycle of its last symbol, so each lasts LEN*SPS cycles
    assign last      = sym_end && sym_q == cur_last;
    assign sweep     = {1'b0, noise_q} + 9'(NOISE_STEP);
    assign sweep_mag = sweep > 9'(NOISE_MAX) ? 8'(NOISE_MIN) : sweep[7:0];

    always_comb begin
        state_d     = state_q;
        sps_d       = busy ? sps_q + PW'(1) : '0;
        sym_d       = sym_end ? (last ? '0 : sym_q + SW'(1)) : sym_q;
        stop_req_d  = stop_req_q | (busy & stop_i);
        noise_d     = noise_q;
        frame_cnt_d = frame_cnt_q;
        fs_d        = 1'b0;
        fd_d        = 1'b0;
        if (!busy && start_i) begin
            state_d    = PRE;
            fs_d       = 1'b1;
            stop_req_d = stop_i;
            noise_d    = auto_sweep_i ? noise_q : noise_manual_i;
        end else if (last && state_q != GRD) begin
            state_d = state_q == PRE ? PAY : GRD;
        end else if (last) begin
            fd_d        = 1'b1;
            frame_cnt_d = frame_cnt_q == 16'hFFFF ? frame_cnt_q : frame_cnt_q + 16'd1;
            noise_d     = auto_sweep_i ? sweep_mag : noise_q;
            if (stop_req_q || stop_i) begin
                state_d    = IDLE;
                stop_req_d = 1'b0;
                sps_d      = '0;
            end else begin
                state_d = PRE;
                fs_d    = 1'b1;
                noise_d = auto_sweep_i ? sweep_mag : noise_manual_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sps_q       <= '0;
            sym_q       <= '0;
            frame_cnt_q <= '0;
            noise_q     <= 8'(NOISE_MIN);
            stop_req_q  <= 1'b0;
            fs_q        <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sps_q       <= sps_d;
            sym_q       <= sym_d;
            frame_cnt_q <= frame_cnt_d;
            noise_q     <= noise_d;
            stop_req_q  <= stop_req_d;
            fs_q        <= fs_d;
            fd_q        <= fd_d;
        end
    end

    assign sym_tick_o    = sym_tick;
    assign payload_en_o  = sym_tick && state_q == PAY;
    assign pre_valid_o   = sym_tick && state_q == PRE;
    assign pre_bits_o    = state_q == PRE ? {4{sym_q[0]}} : 4'h0;
    assign src_sel_o     = state_q == PRE ? 2'd1 : state_q == PAY ? 2'd2 : 2'd0;
    assign noise_mag_o   = noise_q;
    assign frame_start_o = fs_q;
    assign frame_done_o  = fd_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign busy_o        = busy;
endmodule
